// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and helpers for the pipelined adder/subtractor
package addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int COUT   = 0;
    localparam int OVF    = 1;
    localparam int ZERO   = 2;
    localparam int NEG    = 3;
    localparam int NFLAGS = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// rtl/addsub_stage.sv - one CHUNK-bit combinational ripple segment of the pipelined adder
module addsub_stage #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic carry;

    // cmsb captures the carry entering the top bit, needed for signed overflow
    always_comb begin
        carry = cin;
        cmsb  = cin;
        sum   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cmsb   = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

    assign cout = carry;

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined two's-complement adder/subtractor with valid/ready flow control
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0 || STAGES < 1) begin : g_param_check
        $fatal(1, "addsub_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
    logic             st_sub [STAGES];
    logic [CHUNK-1:0] st_sum [STAGES];
    logic             st_co  [STAGES];
    logic             st_cm  [STAGES];
    logic [WIDTH-1:0] a_nxt  [STAGES];
    logic [WIDTH-1:0] b_nxt  [STAGES];

    logic             vld_q  [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic             cy_q   [STAGES];
    logic             sub_q  [STAGES];

    logic [WIDTH-1:0]  sum_fin;
    logic [NFLAGS-1:0] flags_nxt;
    logic [NFLAGS-1:0] flags_q;

    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    // The a word rotates right one chunk per stage while resolved sum chunks
    // enter at the top, so after the last stage it holds the full sum in order.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_a[k]   = in_a;
            assign st_b[k]   = (in_sub == SUB) ? ~in_b : in_b;
            assign st_c[k]   = (in_sub == ADD) ? in_cin : ~in_cin;
            assign st_v[k]   = in_valid;
            assign st_sub[k] = in_sub;
        end else begin : g_body
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_c[k]   = cy_q[k-1];
            assign st_v[k]   = vld_q[k-1];
            assign st_sub[k] = sub_q[k-1];
        end

        addsub_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .a    (st_a[k][CHUNK-1:0]),
            .b    (st_b[k][CHUNK-1:0]),
            .cin  (st_c[k]),
            .sum  (st_sum[k]),
            .cout (st_co[k]),
            .cmsb (st_cm[k])
        );

        assign a_nxt[k] = (st_a[k] >> CHUNK) | (WIDTH'(st_sum[k]) << (WIDTH - CHUNK));
        assign b_nxt[k] = (st_b[k] >> CHUNK) | (st_b[k] << (WIDTH - CHUNK));
    end

    assign sum_fin = a_nxt[STAGES-1];

    always_comb begin
        flags_nxt       = '0;
        flags_nxt[COUT] = st_co[STAGES-1] ^ st_sub[STAGES-1];
        flags_nxt[OVF]  = st_co[STAGES-1] ^ st_cm[STAGES-1];
        flags_nxt[ZERO] = (sum_fin == '0);
        flags_nxt[NEG]  = sum_fin[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                cy_q[i]  <= 1'b0;
                sub_q[i] <= 1'b0;
            end
            flags_q <= '0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= st_v[i];
                a_q[i]   <= a_nxt[i];
                b_q[i]   <= b_nxt[i];
                cy_q[i]  <= st_co[i];
                sub_q[i] <= st_sub[i];
            end
            flags_q <= flags_nxt;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = a_q[STAGES-1];
    assign out_cout  = flags_q[COUT];
    assign out_ovf   = flags_q[OVF];
    assign out_zero  = flags_q[ZERO];
    assign out_neg   = flags_q[NEG];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - self-checking bench for addsub_pipe against an arithmetic reference model
module tb_addsub_pipe;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];
    logic stall_prev = 1'b0;
    res_t held;

    addsub_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Integer arithmetic: result wraps mod 2^16, carry/borrow from the unsigned
    // range, overflow from the signed range of the exact result.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        res_t r;
        int   ua = a;
        int   ub = b;
        int   sa = $signed(a);
        int   sb = $signed(b);
        int   ci = cin;
        int   u;
        int   s;
        if (!sub) begin
            u      = ua + ub + ci;
            s      = sa + sb + ci;
            r.cout = (u > 65535);
        end else begin
            u      = ua - ub - ci;
            s      = sa - sb - ci;
            r.cout = (u < 0);
        end
        r.sum  = u[15:0];
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.sum == 16'h0000);
        r.neg  = r.sum[15];
        return r;
    endfunction

    function automatic res_t dut_res();
        return {out_sum, out_cout, out_ovf, out_zero, out_neg};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev <= 1'b0;
        end else begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (stall_prev)
                check("stall_hold", {12'd0, dut_res()}, {12'd0, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got 0x%0h, expected no result", dut_res());
                end else begin
                    check("result", {12'd0, dut_res()}, {12'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
            stall_prev <= out_valid && !out_ready;
            held       <= dut_res();
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin, input logic [15:0] e_sum,
                            input logic e_c, input logic e_o, input logic e_z, input logic e_n);
        drain();
        out_ready = 1'b1;
        issue(a, b, sub, cin);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_sum"}, {16'd0, out_sum}, {16'd0, e_sum});
        check({name, "_flags"}, {28'd0, out_cout, out_ovf, out_zero, out_neg},
              {28'd0, e_c, e_o, e_z, e_n});
    endtask

    task automatic rand_phase(input int nops, input bit toggle);
        bit done = 1'b0;
        out_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < nops; n++) begin
                    if (!toggle) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                int t = 0;
                while (!done && t < 5000) begin
                    @(posedge clk);
                    #1;
                    out_ready = toggle ? ~out_ready : ($urandom_range(0, 3) != 0);
                    t++;
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_sum", {16'd0, out_sum}, 32'd0);
        check("reset_flags", {28'd0, out_cout, out_ovf, out_zero, out_neg}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        directed("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("sub_borrow",16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("sub_bin",   16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);

        rand_phase(8, 1'b1);
        rand_phase(80, 1'b0);

        // Asynchronous reset with three ops in flight and the head one stalled at the output
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++)
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_sum", {16'd0, out_sum}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();
        directed("post_rst", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
